// File: rtl/atm_account_server.sv
// Account store and request responder for the ATM subsystem: one request at a
// time, checked in priority order, applied to a small per-account register file.
module atm_account_server #(
  parameter int          NUM_ACCOUNTS = 4,
  parameter int          INIT_BALANCE = 1000,
  parameter logic [16:0] DEFAULT_PIN  = 17'h01234,
  parameter int          MAX_TRIES    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_opcode,
  input  logic [16:0] req_account,
  input  logic [16:0] req_password,
  input  logic [16:0] req_dest_account,
  input  logic [18:0] req_amount,
  input  logic [16:0] req_new_pin,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [2:0]  rsp_status,
  output logic [18:0] rsp_balance
);

  localparam int IW = (NUM_ACCOUNTS > 1) ? $clog2(NUM_ACCOUNTS) : 1;
  localparam int CW = $clog2(MAX_TRIES + 1);
  localparam logic [16:0] NUM_ACC  = 17'(NUM_ACCOUNTS);
  localparam logic [18:0] INIT_BAL = 19'(INIT_BALANCE);
  localparam logic [CW-1:0] TRIES  = CW'(MAX_TRIES);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHECK  = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_CREDIT = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  localparam logic [2:0] OP_VERIFY   = 3'd0;
  localparam logic [2:0] OP_BALANCE  = 3'd1;
  localparam logic [2:0] OP_WITHDRAW = 3'd2;
  localparam logic [2:0] OP_DEPOSIT  = 3'd3;
  localparam logic [2:0] OP_TRANSFER = 3'd4;
  localparam logic [2:0] OP_CHPIN    = 3'd5;

  localparam logic [2:0] ST_OK       = 3'd0;
  localparam logic [2:0] ST_BAD_OP   = 3'd1;
  localparam logic [2:0] ST_BAD_ACC  = 3'd2;
  localparam logic [2:0] ST_LOCKED   = 3'd3;
  localparam logic [2:0] ST_BAD_PIN  = 3'd4;
  localparam logic [2:0] ST_INSUFF   = 3'd5;
  localparam logic [2:0] ST_OVERFLOW = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [16:0] acct_q, acct_d;
  logic [16:0] pw_q, pw_d;
  logic [16:0] dest_q, dest_d;
  logic [18:0] amt_q, amt_d;
  logic [16:0] new_pin_q, new_pin_d;
  logic [2:0]  status_q, status_d;
  logic [18:0] bal_q  [NUM_ACCOUNTS];
  logic [18:0] bal_d  [NUM_ACCOUNTS];
  logic [16:0] pin_q  [NUM_ACCOUNTS];
  logic [16:0] pin_d  [NUM_ACCOUNTS];
  logic [CW-1:0] fail_q [NUM_ACCOUNTS];
  logic [CW-1:0] fail_d [NUM_ACCOUNTS];
  logic [NUM_ACCOUNTS-1:0] lock_q, lock_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [2:0]  rsp_status_q, rsp_status_d;
  logic [18:0] rsp_balance_q, rsp_balance_d;

  logic [IW-1:0] src_idx_s, dst_idx_s;
  logic [18:0]   src_bal_s, dst_bal_s;
  logic [19:0]   dep_sum_s, dst_sum_s;
  logic          pin_ok_s;
  logic [2:0]    chk_status_s;

  assign src_idx_s = acct_q[IW-1:0];
  assign dst_idx_s = dest_q[IW-1:0];
  assign src_bal_s = bal_q[src_idx_s];
  assign dst_bal_s = bal_q[dst_idx_s];
  // 20-bit sums so a carry into bit 19 flags overflow instead of wrapping
  assign dep_sum_s = {1'b0, src_bal_s} + {1'b0, amt_q};
  assign dst_sum_s = {1'b0, dst_bal_s} + {1'b0, amt_q};
  assign pin_ok_s  = (pw_q == pin_q[src_idx_s]);

  always_comb begin
    chk_status_s = ST_OK;
    if (op_q > OP_CHPIN) begin
      chk_status_s = ST_BAD_OP;
    end else if (acct_q >= NUM_ACC) begin
      chk_status_s = ST_BAD_ACC;
    end else if (lock_q[src_idx_s]) begin
      chk_status_s = ST_LOCKED;
    end else if (!pin_ok_s) begin
      chk_status_s = ST_BAD_PIN;
    end else begin
      case (op_q)
        OP_WITHDRAW: chk_status_s = (amt_q > src_bal_s) ? ST_INSUFF : ST_OK;
        OP_DEPOSIT:  chk_status_s = dep_sum_s[19] ? ST_OVERFLOW : ST_OK;
        OP_TRANSFER: begin
          if (amt_q > src_bal_s) begin
            chk_status_s = ST_INSUFF;
          end else if ((dest_q >= NUM_ACC) || (dest_q == acct_q)) begin
            chk_status_s = ST_BAD_ACC;
          end else if (dst_sum_s[19]) begin
            chk_status_s = ST_OVERFLOW;
          end else begin
            chk_status_s = ST_OK;
          end
        end
        default: chk_status_s = ST_OK;
      endcase
    end
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    acct_d        = acct_q;
    pw_d          = pw_q;
    dest_d        = dest_q;
    amt_d         = amt_q;
    new_pin_d     = new_pin_q;
    status_d      = status_q;
    bal_d         = bal_q;
    pin_d         = pin_q;
    fail_d        = fail_q;
    lock_d        = lock_q;
    req_ready_d   = req_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_status_d  = rsp_status_q;
    rsp_balance_d = rsp_balance_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d        = req_opcode;
          acct_d      = req_account;
          pw_d        = req_password;
          dest_d      = req_dest_account;
          amt_d       = req_amount;
          new_pin_d   = req_new_pin;
          req_ready_d = 1'b0;
          state_d     = S_CHECK;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CHECK: begin
        status_d = chk_status_s;
        // Fail counter only moves once the account is known valid and unlocked
        if (chk_status_s == ST_BAD_PIN) begin
          fail_d[src_idx_s] = fail_q[src_idx_s] + CW'(1);
          if (fail_q[src_idx_s] + CW'(1) >= TRIES) begin
            lock_d[src_idx_s] = 1'b1;
          end else begin
            lock_d[src_idx_s] = lock_q[src_idx_s];
          end
        end else if ((op_q <= OP_CHPIN) && (acct_q < NUM_ACC) &&
                     !lock_q[src_idx_s] && pin_ok_s) begin
          fail_d[src_idx_s] = {CW{1'b0}};
        end else begin
          fail_d = fail_q;
        end
        state_d = S_EXEC;
      end
      S_EXEC: begin
        rsp_status_d  = status_q;
        rsp_balance_d = 19'd0;
        if (status_q == ST_OK) begin
          case (op_q)
            OP_WITHDRAW, OP_TRANSFER: begin
              bal_d[src_idx_s] = src_bal_s - amt_q;
              rsp_balance_d    = src_bal_s - amt_q;
            end
            OP_DEPOSIT: begin
              bal_d[src_idx_s] = dep_sum_s[18:0];
              rsp_balance_d    = dep_sum_s[18:0];
            end
            OP_CHPIN: begin
              pin_d[src_idx_s] = new_pin_q;
              rsp_balance_d    = src_bal_s;
            end
            default: rsp_balance_d = src_bal_s;
          endcase
        end else if (status_q == ST_INSUFF) begin
          rsp_balance_d = src_bal_s;
        end else begin
          rsp_balance_d = 19'd0;
        end
        if ((status_q == ST_OK) && (op_q == OP_TRANSFER)) begin
          state_d = S_CREDIT;
        end else begin
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_CREDIT: begin
        bal_d[dst_idx_s] = dst_sum_s[18:0];
        rsp_valid_d      = 1'b1;
        state_d          = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        req_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      op_q          <= 3'd0;
      acct_q        <= 17'd0;
      pw_q          <= 17'd0;
      dest_q        <= 17'd0;
      amt_q         <= 19'd0;
      new_pin_q     <= 17'd0;
      status_q      <= ST_OK;
      lock_q        <= {NUM_ACCOUNTS{1'b0}};
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_status_q  <= 3'd0;
      rsp_balance_q <= 19'd0;
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        bal_q[i]  <= INIT_BAL;
        pin_q[i]  <= DEFAULT_PIN;
        fail_q[i] <= {CW{1'b0}};
      end
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      acct_q        <= acct_d;
      pw_q          <= pw_d;
      dest_q        <= dest_d;
      amt_q         <= amt_d;
      new_pin_q     <= new_pin_d;
      status_q      <= status_d;
      lock_q        <= lock_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_status_q  <= rsp_status_d;
      rsp_balance_q <= rsp_balance_d;
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        bal_q[i]  <= bal_d[i];
        pin_q[i]  <= pin_d[i];
        fail_q[i] <= fail_d[i];
      end
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_status  = rsp_status_q;
  assign rsp_balance = rsp_balance_q;

endmodule

// File: tb/tb_atm_account_server.sv
// Bench for atm_account_server: directed scenarios plus random traffic, all
// compared against a plain account-book model held in the bench.
module tb_atm_account_server;
  localparam int NACC = 4;
  localparam int MAXB = 524287;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_opcode;
  logic [16:0] req_account;
  logic [16:0] req_password;
  logic [16:0] req_dest_account;
  logic [18:0] req_amount;
  logic [16:0] req_new_pin;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [2:0]  rsp_status;
  logic [18:0] rsp_balance;

  int checks = 0;
  int errors = 0;

  int m_bal  [NACC];
  int m_pin  [NACC];
  int m_fail [NACC];
  int m_lock [NACC];

  atm_account_server dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_account(req_account), .req_password(req_password),
    .req_dest_account(req_dest_account), .req_amount(req_amount),
    .req_new_pin(req_new_pin), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_status(rsp_status), .rsp_balance(rsp_balance)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < NACC; i++) begin
      m_bal[i] = 1000; m_pin[i] = 'h01234; m_fail[i] = 0; m_lock[i] = 0;
    end
  endtask

  // Bank rules applied to the model; returns the status and balance the ATM should see
  task automatic model_req(input int op, input int acct, input int pw, input int dest,
                           input int amt, input int npin, output int st, output int b);
    st = 0; b = 0;
    if (op > 5) st = 1;
    else if (acct >= NACC) st = 2;
    else if (m_lock[acct] != 0) st = 3;
    else if (pw != m_pin[acct]) begin
      m_fail[acct]++;
      if (m_fail[acct] >= 3) m_lock[acct] = 1;
      st = 4;
    end else begin
      m_fail[acct] = 0;
      case (op)
        2: if (amt > m_bal[acct]) st = 5; else m_bal[acct] -= amt;
        3: if (m_bal[acct] + amt > MAXB) st = 6; else m_bal[acct] += amt;
        4: begin
          if (amt > m_bal[acct]) st = 5;
          else if (dest >= NACC || dest == acct) st = 2;
          else if (m_bal[dest] + amt > MAXB) st = 6;
          else begin m_bal[acct] -= amt; m_bal[dest] += amt; end
        end
        5: m_pin[acct] = npin;
        default: ;
      endcase
      if (st == 0 || st == 5) b = m_bal[acct];
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    #12;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic do_req(input string name, input logic [2:0] op, input logic [16:0] acct,
                        input logic [16:0] pw, input logic [16:0] dest, input logic [18:0] amt,
                        input logic [16:0] npin, input int hold);
    int est, ebal, elat, edges;
    logic [2:0]  st0;
    logic [18:0] b0;
    model_req(int'(op), int'(acct), int'(pw), int'(dest), int'(amt), int'(npin), est, ebal);
    elat = (op == 3'd4 && est == 0) ? 4 : 3;
    edges = 0;
    while (req_ready !== 1'b1 && edges < 20) begin @(posedge clk); #1; edges++; end
    req_valid = 1'b1; req_opcode = op; req_account = acct; req_password = pw;
    req_dest_account = dest; req_amount = amt; req_new_pin = npin;
    @(posedge clk); #1;
    req_valid = 1'b0;
    edges = 1;
    while (rsp_valid !== 1'b1 && edges < 20) begin @(posedge clk); #1; edges++; end
    checks++;
    if (rsp_valid !== 1'b1) begin
      $display("FAIL %s timeout: rsp_valid=%b after %0d edges, required 1", name, rsp_valid, edges);
      errors++;
      return;
    end
    checks++;
    if (edges !== elat) begin
      $display("FAIL %s latency: got %0d edges, required %0d", name, edges, elat); errors++;
    end
    checks++;
    if (rsp_status !== 3'(est)) begin
      $display("FAIL %s status: got %0d, required %0d", name, rsp_status, est); errors++;
    end
    checks++;
    if (rsp_balance !== 19'(ebal)) begin
      $display("FAIL %s balance: got %0d, required %0d", name, rsp_balance, ebal); errors++;
    end
    st0 = rsp_status; b0 = rsp_balance;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_status !== st0 || rsp_balance !== b0 || req_ready !== 1'b0) begin
        $display("FAIL %s hold%0d: valid=%b st=%0d bal=%0d rdy=%b, required 1/%0d/%0d/0",
                 name, i, rsp_valid, rsp_status, rsp_balance, req_ready, st0, b0);
        errors++;
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      $display("FAIL %s release: rsp_valid=%b req_ready=%b, required 0/1", name, rsp_valid, req_ready);
      errors++;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_status !== 3'd0 || rsp_balance !== 19'd0) begin
      $display("FAIL reset_state: rdy=%b valid=%b st=%0d bal=%0d, required 1/0/0/0",
               req_ready, rsp_valid, rsp_status, rsp_balance);
      errors++;
    end
  endtask

  task automatic test_balance_query();
    do_req("bal_acct2", 3'd1, 17'd2, 17'h01234, 17'd0, 19'd0, 17'd0, 0);
    do_req("verify_acct0", 3'd0, 17'd0, 17'h01234, 17'd0, 19'd0, 17'd0, 0);
  endtask

  task automatic test_withdraw();
    do_req("wd300", 3'd2, 17'd1, 17'h01234, 17'd0, 19'd300, 17'd0, 0);
    do_req("wd800", 3'd2, 17'd1, 17'h01234, 17'd0, 19'd800, 17'd0, 0);
    do_req("wd0", 3'd2, 17'd1, 17'h01234, 17'd0, 19'd0, 17'd0, 0);
  endtask

  task automatic test_transfer();
    do_req("xfer0to3", 3'd4, 17'd0, 17'h01234, 17'd3, 19'd250, 17'd0, 0);
    do_req("bal_acct3", 3'd1, 17'd3, 17'h01234, 17'd0, 19'd0, 17'd0, 0);
    do_req("xfer0to0", 3'd4, 17'd0, 17'h01234, 17'd0, 19'd10, 17'd0, 0);
    do_req("xfer_bad_dest", 3'd4, 17'd0, 17'h01234, 17'd5, 19'd10, 17'd0, 0);
  endtask

  task automatic test_lockout();
    do_req("wd_acct2", 3'd2, 17'd2, 17'h01234, 17'd0, 19'd100, 17'd0, 0);
    for (int i = 0; i < 3; i++)
      do_req("bad_pin", 3'd1, 17'd2, 17'h00001, 17'd0, 19'd0, 17'd0, 0);
    do_req("locked", 3'd1, 17'd2, 17'h01234, 17'd0, 19'd0, 17'd0, 0);
    do_req("xfer_to_locked", 3'd4, 17'd1, 17'h01234, 17'd2, 19'd5, 17'd0, 0);
    apply_reset();
    do_req("unlocked", 3'd1, 17'd2, 17'h01234, 17'd0, 19'd0, 17'd0, 0);
  endtask

  task automatic test_errors();
    do_req("dep_overflow", 3'd3, 17'd1, 17'h01234, 17'd0, 19'd524000, 17'd0, 0);
    do_req("bad_op", 3'd7, 17'd0, 17'h01234, 17'd0, 19'd0, 17'd0, 0);
    do_req("bad_acct", 3'd1, 17'd9, 17'h01234, 17'd0, 19'd0, 17'd0, 0);
    do_req("chpin", 3'd5, 17'd3, 17'h01234, 17'd0, 19'd0, 17'h0abcd, 0);
    do_req("old_pin", 3'd1, 17'd3, 17'h01234, 17'd0, 19'd0, 17'd0, 0);
    do_req("new_pin", 3'd1, 17'd3, 17'h0abcd, 17'd0, 19'd0, 17'd0, 0);
  endtask

  task automatic test_backpressure();
    do_req("hold_rsp", 3'd3, 17'd0, 17'h01234, 17'd0, 19'd77, 17'd0, 5);
  endtask

  task automatic test_reset_in_exec();
    int edges;
    apply_reset();
    edges = 0;
    req_valid = 1'b1; req_opcode = 3'd2; req_account = 17'd0; req_password = 17'h01234;
    req_dest_account = 17'd0; req_amount = 19'd400; req_new_pin = 17'd0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      $display("FAIL exec_reset_outputs: valid=%b rdy=%b, required 0/1", rsp_valid, req_ready);
      errors++;
    end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    do_req("after_exec_reset", 3'd1, 17'd0, 17'h01234, 17'd0, 19'd0, 17'd0, 0);
  endtask

  task automatic test_random();
    int r, a, op;
    logic [16:0] pw;
    logic [18:0] amt;
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 7);
      r = $urandom_range(0, 9);
      a = (r < 9) ? (r % NACC) : 9;
      pw = ($urandom_range(0, 9) < 8) ? 17'(m_pin[a % NACC]) : 17'($urandom);
      amt = ($urandom_range(0, 3) == 0) ? 19'd524000 : 19'($urandom_range(0, 1500));
      do_req("random", 3'(op), 17'(a), pw, 17'($urandom_range(0, 4)), amt, 17'($urandom), 0);
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_opcode = 3'd0; req_account = 17'd0; req_password = 17'd0;
    req_dest_account = 17'd0; req_amount = 19'd0; req_new_pin = 17'd0;
    model_reset();
    test_reset();
    test_balance_query();
    test_withdraw();
    test_transfer();
    test_lockout();
    test_errors();
    test_backpressure();
    test_reset_in_exec();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/atm_account_server.md
Name: atm_account_server

Overview:
- Bank-side responder that services the transaction requests issued by the ATM controller.
- Holds a small register-file of accounts: PIN, balance and lockout state per account.
- Accepts one request at a time over a valid/ready handshake, checks the request, updates the account state and returns a status and balance over a second valid/ready handshake.
- Sits between the ATM controller and the (future) bank backend; on-chip it is the account store for the whole ATM subsystem.

Parameters:
- NUM_ACCOUNTS, 4, number of accounts (2..16); valid account numbers are 0..NUM_ACCOUNTS-1.
- INIT_BALANCE, 1000, balance of every account after reset.
- DEFAULT_PIN, 17'h01234, PIN of every account after reset.
- MAX_TRIES, 3, consecutive wrong PINs that lock an account.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  server can accept a request.
- req_opcode  in  3  000 verify PIN, 001 balance, 010 withdraw, 011 deposit, 100 transfer, 101 change PIN; 110/111 are illegal.
- req_account  in  17  source account number.
- req_password  in  17  PIN presented for the source account.
- req_dest_account  in  17  destination account (transfer only).
- req_amount  in  19  amount for withdraw, deposit or transfer.
- req_new_pin  in  17  new PIN (change PIN only).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  ATM accepts the response.
- rsp_status  out  3  0 OK, 1 BAD_OP, 2 BAD_ACCOUNT, 3 LOCKED, 4 BAD_PIN, 5 INSUFFICIENT, 6 OVERFLOW.
- rsp_balance  out  19  source balance after the operation.

Behaviour:
- Reset (reset low, asynchronous):
  - FSM goes to IDLE.
  - All balances load INIT_BALANCE; all PINs load DEFAULT_PIN; fail counters and lock bits clear.
  - req_ready=1, rsp_valid=0, rsp_status=0, rsp_balance=0.
  - A reset mid-transaction discards the transaction; no partial update survives.
- FSM states: IDLE -> CHECK -> EXEC -> [CREDIT] -> RESP -> IDLE.
- IDLE:
  - req_ready=1 only in IDLE.
  - On an edge with req_valid=1, all request fields are captured and the FSM moves to CHECK.
- CHECK evaluates in strict priority order:
  1. Illegal opcode -> BAD_OP.
  2. Source account >= NUM_ACCOUNTS -> BAD_ACCOUNT.
  3. Source account locked -> LOCKED; the PIN is not compared.
  4. PIN mismatch -> BAD_PIN. The fail counter increments; when it reaches MAX_TRIES the lock bit sets.
  5. PIN match clears the fail counter, then the op-specific checks run:
     - Withdraw or transfer with amount > balance -> INSUFFICIENT.
     - Deposit with balance+amount > 2^19-1 -> OVERFLOW.
     - Transfer with destination >= NUM_ACCOUNTS or destination equal to source -> BAD_ACCOUNT.
     - Transfer with destination balance+amount > 2^19-1 -> OVERFLOW.
  - The destination account's lock state does not block a transfer.
- EXEC:
  - Runs only when the status is OK; no account state changes on any error.
  - Withdraw subtracts the amount from the source; transfer debits the source.
  - Deposit adds the amount; change PIN writes req_new_pin.
  - Verify PIN and balance make no change.
- CREDIT: transfer only; adds the amount to the destination balance.
- Arithmetic: 20-bit sums for the overflow checks; no wrap is ever stored. An amount of 0 is legal and returns OK with the balance unchanged.
- RESP:
  - rsp_valid=1; rsp_status and rsp_balance are held stable until the edge where rsp_ready=1, then the FSM returns to IDLE.
  - rsp_balance gives the post-op source balance for OK and INSUFFICIENT, and 0 for all other statuses.
- Latency: rsp_valid rises 3 edges after the accepting edge (4 for an OK transfer). Minimum request-to-request spacing is 4 cycles.
- Only reset clears a lock.

Test Plan:
- Reset release -> req_ready=1, rsp_valid=0, rsp_status=0, rsp_balance=0. Balance query on account 2 with PIN 17'h01234 -> OK, 1000, rsp_valid on the 3rd edge after acceptance.
- Withdraw 300 from account 1, then withdraw 800 -> OK with 700, then INSUFFICIENT with 700 unchanged.
- Transfer 250 from account 0 to account 3 -> OK with 750 on the 4th edge. Balance query on account 3 -> 1250. Transfer from 0 to 0 -> BAD_ACCOUNT.
- Three wrong PINs on account 2 -> BAD_PIN x3. Next request with the correct PIN -> LOCKED. Reset -> account 2 unlocked and its balance back to 1000.
- Deposit 524000 to account 1 -> OVERFLOW, balance unchanged. Opcode 3'b111 -> BAD_OP. Account 17'd9 -> BAD_ACCOUNT, rsp_balance=0.
- Hold rsp_ready=0 for 5 cycles -> response fields stable and req_ready=0. Assert reset in EXEC of a withdraw -> balance stays at INIT_BALANCE.
